// File: rtl/ofs_plat_prim_rdwr_burst_arbiter.sv
// ofs_plat_prim_rdwr_burst_arbiter
//
// Merges a read request stream (ch0, one beat per burst) and a write stream
// (ch1, multi-beat bursts) into a single Avalon-style request stream held in a
// one-deep registered output stage. Once a write burst starts it owns the
// output until its last beat, so the write data of a burst is never split.
// Per-burst accept pulses feed the upstream burst-count fairness tracker, and
// its favor_ch0/favor_ch1 flags bias the tie-break between the channels.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   ch0_valid/ready           read request handshake
//   ch0_burstcount/payload    read burst length and payload
//   ch1_valid/ready           write beat handshake
//   ch1_sop                   first beat of a write burst
//   ch1_burstcount/payload    write burst length (sop beat only) and payload
//   favor_ch0, favor_ch1      fairness tracker bias
//   out_valid/ready           merged request handshake
//   out_is_write, out_sop     beat source and first-beat flag
//   out_burstcount/payload    burst length and payload of the merged beat
//   fair_ch0_valid/burstcount read burst accepted this cycle
//   fair_ch1_valid/burstcount write burst (sop beat) accepted this cycle

module ofs_plat_prim_rdwr_burst_arbiter #(
    parameter int BURST_CNT_WIDTH = 7,
    parameter int PAYLOAD_WIDTH   = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,

    input  logic                       ch0_valid,
    output logic                       ch0_ready,
    input  logic [BURST_CNT_WIDTH-1:0] ch0_burstcount,
    input  logic [PAYLOAD_WIDTH-1:0]   ch0_payload,

    input  logic                       ch1_valid,
    output logic                       ch1_ready,
    input  logic                       ch1_sop,
    input  logic [BURST_CNT_WIDTH-1:0] ch1_burstcount,
    input  logic [PAYLOAD_WIDTH-1:0]   ch1_payload,

    input  logic                       favor_ch0,
    input  logic                       favor_ch1,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_is_write,
    output logic                       out_sop,
    output logic [BURST_CNT_WIDTH-1:0] out_burstcount,
    output logic [PAYLOAD_WIDTH-1:0]   out_payload,

    output logic                       fair_ch0_valid,
    output logic [BURST_CNT_WIDTH-1:0] fair_ch0_burstcount,
    output logic                       fair_ch1_valid,
    output logic [BURST_CNT_WIDTH-1:0] fair_ch1_burstcount
);

    localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE = BURST_CNT_WIDTH'(1);

    // Remaining non-sop beats of the write burst in flight; nonzero = locked.
    logic [BURST_CNT_WIDTH-1:0] beats_left;
    // Length of the write burst in flight, replayed on its non-sop beats.
    logic [BURST_CNT_WIDTH-1:0] burst_len;
    // 1 when the most recent accepted beat came from ch1.
    logic                       last_grant_ch1;

    logic                       locked;
    logic                       stage_en;
    logic                       pick_ch0;
    logic                       grant_ch0;
    logic                       grant_ch1;
    logic                       acc0;
    logic                       acc1;
    logic                       acc1_sop;
    logic [BURST_CNT_WIDTH-1:0] ch0_bc;
    logic [BURST_CNT_WIDTH-1:0] ch1_bc;

    assign locked   = (beats_left != '0);
    assign stage_en = !out_valid || out_ready;

    // Tie-break when both channels want the stage. favor_ch0 outranks
    // favor_ch1, which also settles the illegal both-high case.
    assign pick_ch0 = favor_ch0 || (!favor_ch1 && last_grant_ch1);

    // Each grant looks only at the other channel's valid, so neither ready
    // depends on its own channel's valid. With nothing pending both grants
    // are high, which is harmless since no accept can happen.
    assign grant_ch0 = !locked && (!ch1_valid || pick_ch0);
    assign grant_ch1 = locked || !ch0_valid || !pick_ch0;

    // Readies are forced low while reset is held so no accept pulse leaks
    // to the fairness tracker during reset.
    assign ch0_ready = reset_n && stage_en && grant_ch0;
    assign ch1_ready = reset_n && stage_en && grant_ch1;

    assign acc0     = ch0_valid && ch0_ready;
    assign acc1     = ch1_valid && ch1_ready;
    // Any unlocked write beat starts a burst, even without sop (protocol
    // error: it is treated as a 1-beat burst).
    assign acc1_sop = acc1 && !locked;

    // Zero burstcount is illegal and treated as 1.
    assign ch0_bc = (ch0_burstcount == '0) ? BC_ONE : ch0_burstcount;
    assign ch1_bc = (!ch1_sop || ch1_burstcount == '0) ? BC_ONE : ch1_burstcount;

    assign fair_ch0_valid      = acc0;
    assign fair_ch0_burstcount = acc0 ? ch0_bc : '0;
    assign fair_ch1_valid      = acc1_sop;
    assign fair_ch1_burstcount = acc1_sop ? ch1_bc : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            out_is_write   <= 1'b0;
            out_sop        <= 1'b0;
            out_burstcount <= '0;
            out_payload    <= '0;
            beats_left     <= '0;
            burst_len      <= '0;
            last_grant_ch1 <= 1'b1;
        end else if (stage_en) begin
            out_valid <= acc0 || acc1;
            if (acc0) begin
                out_is_write   <= 1'b0;
                out_sop        <= 1'b1;
                out_burstcount <= ch0_bc;
                out_payload    <= ch0_payload;
                last_grant_ch1 <= 1'b0;
            end else if (acc1) begin
                out_is_write   <= 1'b1;
                out_payload    <= ch1_payload;
                last_grant_ch1 <= 1'b1;
                if (locked) begin
                    out_sop        <= 1'b0;
                    out_burstcount <= burst_len;
                    beats_left     <= beats_left - BC_ONE;
                end else begin
                    // ch1_bc >= 1, so N-1 never wraps, including N = 2^W-1.
                    out_sop        <= 1'b1;
                    out_burstcount <= ch1_bc;
                    burst_len      <= ch1_bc;
                    beats_left     <= ch1_bc - BC_ONE;
                end
            end
        end
    end

    // Protocol checks on the upstream channels.
    a_ch1_sop_unlocked: assert property (
        @(posedge clk) disable iff (!reset_n)
        (ch1_valid && ch1_ready && !locked) |-> ch1_sop);

    a_ch1_bc_nonzero: assert property (
        @(posedge clk) disable iff (!reset_n)
        (ch1_valid && ch1_ready && !locked && ch1_sop) |-> (ch1_burstcount != '0));

    a_ch0_bc_nonzero: assert property (
        @(posedge clk) disable iff (!reset_n)
        (ch0_valid && ch0_ready) |-> (ch0_burstcount != '0));

endmodule

// File: tb/tb_ofs_plat_prim_rdwr_burst_arbiter.sv
// Directed bench for ofs_plat_prim_rdwr_burst_arbiter. Inputs change 1 time
// unit after the rising edge; combinational outputs are sampled 1 unit later
// and registered outputs 1 unit after the following rising edge.

module tb_ofs_plat_prim_rdwr_burst_arbiter;

    localparam int BW = 7;
    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ch0_valid = 1'b0;
    logic          ch0_ready;
    logic [BW-1:0] ch0_burstcount = '0;
    logic [PW-1:0] ch0_payload = '0;
    logic          ch1_valid = 1'b0;
    logic          ch1_ready;
    logic          ch1_sop = 1'b0;
    logic [BW-1:0] ch1_burstcount = '0;
    logic [PW-1:0] ch1_payload = '0;
    logic          favor_ch0 = 1'b0;
    logic          favor_ch1 = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_is_write;
    logic          out_sop;
    logic [BW-1:0] out_burstcount;
    logic [PW-1:0] out_payload;
    logic          fair_ch0_valid;
    logic [BW-1:0] fair_ch0_burstcount;
    logic          fair_ch1_valid;
    logic [BW-1:0] fair_ch1_burstcount;

    int total = 0;
    int bad   = 0;

    ofs_plat_prim_rdwr_burst_arbiter #(
        .BURST_CNT_WIDTH(BW),
        .PAYLOAD_WIDTH  (PW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .ch0_valid          (ch0_valid),
        .ch0_ready          (ch0_ready),
        .ch0_burstcount     (ch0_burstcount),
        .ch0_payload        (ch0_payload),
        .ch1_valid          (ch1_valid),
        .ch1_ready          (ch1_ready),
        .ch1_sop            (ch1_sop),
        .ch1_burstcount     (ch1_burstcount),
        .ch1_payload        (ch1_payload),
        .favor_ch0          (favor_ch0),
        .favor_ch1          (favor_ch1),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_is_write       (out_is_write),
        .out_sop            (out_sop),
        .out_burstcount     (out_burstcount),
        .out_payload        (out_payload),
        .fair_ch0_valid     (fair_ch0_valid),
        .fair_ch0_burstcount(fair_ch0_burstcount),
        .fair_ch1_valid     (fair_ch1_valid),
        .fair_ch1_burstcount(fair_ch1_burstcount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic wr, input logic sop,
                           input logic [BW-1:0] bc, input logic [PW-1:0] pl);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".wr"}, 64'(out_is_write), 64'(wr));
        chk({tag, ".sop"}, 64'(out_sop), 64'(sop));
        chk({tag, ".bc"}, 64'(out_burstcount), 64'(bc));
        chk({tag, ".pl"}, out_payload, pl);
    endtask

    initial begin
        int cnt;
        logic wr;

        // ---- reset state, then a single read right after release
        ch0_valid = 1'b1; ch0_burstcount = 7'd1; ch0_payload = 64'hA1;
        tick; tick; #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_payload", out_payload, 64'd0);
        chk("rst.out_bc", 64'(out_burstcount), 64'd0);
        chk("rst.fair0", 64'(fair_ch0_valid), 64'd0);
        chk("rst.ch0_ready", 64'(ch0_ready), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("t1.ch0_ready", 64'(ch0_ready), 64'd1);
        chk("t1.fair0_v", 64'(fair_ch0_valid), 64'd1);
        chk("t1.fair0_bc", 64'(fair_ch0_burstcount), 64'd1);
        tick;
        chk_out("t1.out", 1'b0, 1'b1, 7'd1, 64'hA1);

        // ---- 4-beat write with a read pending throughout
        ch0_payload = 64'hB1;
        ch1_valid = 1'b1; ch1_sop = 1'b1; ch1_burstcount = 7'd4; ch1_payload = 64'hC0;
        #1;
        chk("t2.ch1_ready", 64'(ch1_ready), 64'd1);
        chk("t2.ch0_ready", 64'(ch0_ready), 64'd0);
        chk("t2.fair1_v", 64'(fair_ch1_valid), 64'd1);
        chk("t2.fair1_bc", 64'(fair_ch1_burstcount), 64'd4);
        tick;
        chk_out("t2.b0", 1'b1, 1'b1, 7'd4, 64'hC0);
        for (int i = 1; i < 4; i++) begin
            ch1_sop = 1'b0; ch1_burstcount = 7'd0; ch1_payload = 64'hC0 + 64'(i);
            #1;
            chk("t2.lock.ch0_ready", 64'(ch0_ready), 64'd0);
            chk("t2.lock.ch1_ready", 64'(ch1_ready), 64'd1);
            chk("t2.lock.fair1", 64'(fair_ch1_valid), 64'd0);
            tick;
            chk_out("t2.bn", 1'b1, 1'b0, 7'd4, 64'hC0 + 64'(i));
        end
        ch1_valid = 1'b0;
        #1;
        chk("t2.unlock.ch0_ready", 64'(ch0_ready), 64'd1);
        tick;
        chk_out("t2.rd", 1'b0, 1'b1, 7'd1, 64'hB1);

        // ---- round-robin alternation from reset, no favor
        reset_n = 1'b0; ch0_valid = 1'b0;
        #1;
        chk("t3.rst.out_valid", 64'(out_valid), 64'd0);
        tick;
        reset_n = 1'b1;
        ch0_valid = 1'b1; ch1_valid = 1'b1; ch1_sop = 1'b1; ch1_burstcount = 7'd1;
        for (int i = 0; i < 4; i++) begin
            wr = 1'(i % 2);
            ch0_payload = 64'h30 + 64'(i);
            ch1_payload = 64'h40 + 64'(i);
            #1;
            chk("t3.ch0_ready", 64'(ch0_ready), 64'(!wr));
            chk("t3.ch1_ready", 64'(ch1_ready), 64'(wr));
            tick;
            chk_out("t3.out", wr, 1'b1, 7'd1, wr ? 64'h40 + 64'(i) : 64'h30 + 64'(i));
        end

        // ---- favor_ch1 held, then favor_ch0, then both (ch0 wins)
        favor_ch1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4.f1.ch1_ready", 64'(ch1_ready), 64'd1);
            chk("t4.f1.ch0_ready", 64'(ch0_ready), 64'd0);
            tick;
            chk("t4.f1.wr", 64'(out_is_write), 64'd1);
        end
        favor_ch1 = 1'b0; favor_ch0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t4.f0.ch0_ready", 64'(ch0_ready), 64'd1);
            tick;
            chk("t4.f0.wr", 64'(out_is_write), 64'd0);
        end
        favor_ch1 = 1'b1;
        #1;
        chk("t4.both.ch0_ready", 64'(ch0_ready), 64'd1);
        tick;
        chk("t4.both.wr", 64'(out_is_write), 64'd0);
        favor_ch0 = 1'b0; favor_ch1 = 1'b0;

        // ---- 8-beat write with 3 cycles of output back-pressure
        // last grant is ch0, so the tie goes to ch1
        cnt = 0;
        ch0_payload = 64'h55;
        ch1_burstcount = 7'd8;
        for (int b = 0; b < 3; b++) begin
            ch1_sop = (b == 0); ch1_payload = 64'h80 + 64'(b);
            #1;
            chk("t5.ch1_ready", 64'(ch1_ready), 64'd1);
            if (ch1_ready) cnt++;
            tick;
        end
        out_ready = 1'b0; ch1_sop = 1'b0; ch1_payload = 64'h83;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5.bp.ch1_ready", 64'(ch1_ready), 64'd0);
            chk("t5.bp.ch0_ready", 64'(ch0_ready), 64'd0);
            if (ch1_ready) cnt++;
            tick;
            chk("t5.bp.pl", out_payload, 64'h82);
            chk("t5.bp.valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        for (int b = 3; b < 8; b++) begin
            ch1_payload = 64'h80 + 64'(b);
            #1;
            chk("t5.lock.ch0_ready", 64'(ch0_ready), 64'd0);
            if (ch1_ready) cnt++;
            tick;
            chk_out("t5.bn", 1'b1, 1'b0, 7'd8, 64'h80 + 64'(b));
        end
        ch1_valid = 1'b0;
        #1;
        chk("t5.beats", 64'(cnt), 64'd8);
        chk("t5.unlock.ch0_ready", 64'(ch0_ready), 64'd1);
        tick;
        chk_out("t5.rd", 1'b0, 1'b1, 7'd1, 64'h55);

        // ---- async reset mid-burst (beats_left = 5)
        ch0_valid = 1'b0;
        ch1_valid = 1'b1; ch1_burstcount = 7'd8;
        for (int b = 0; b < 3; b++) begin
            ch1_sop = (b == 0); ch1_payload = 64'h90 + 64'(b);
            tick;
        end
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6.rst.out_valid", 64'(out_valid), 64'd0);
        chk("t6.rst.out_pl", out_payload, 64'd0);
        chk("t6.rst.ch1_ready", 64'(ch1_ready), 64'd0);
        ch1_valid = 1'b0; ch1_sop = 1'b0;
        ch0_valid = 1'b1; ch0_payload = 64'hAA;
        #2;
        reset_n = 1'b1;
        #1;
        chk("t6.ch0_ready", 64'(ch0_ready), 64'd1);
        tick;
        chk_out("t6.rd", 1'b0, 1'b1, 7'd1, 64'hAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofs_plat_prim_rdwr_burst_arbiter.md
Name: ofs_plat_prim_rdwr_burst_arbiter

Overview:
- Two-channel request arbiter that sits directly downstream of the burst-count fairness tracker and consumes its favor_ch0/favor_ch1 flags.
- Merges a read request stream (ch0, one beat per burst) and a write stream (ch1, multi-beat bursts) into a single Avalon-style request stream.
- Output is a one-deep registered pipeline stage.
- Emits per-burst accept pulses with burst counts, which are wired back to the fairness tracker's ch0/ch1 valid/burstcount inputs.

Parameters:
- BURST_CNT_WIDTH, 7, width of burstcount fields; legal values 1..2^BURST_CNT_WIDTH-1.
- PAYLOAD_WIDTH, 64, opaque request payload width (address, byte enables, data), identical on both channels.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous assert, active-low
- ch0_valid  input  1  read request valid
- ch0_ready  output  1  read request accepted when valid&&ready
- ch0_burstcount  input  BURST_CNT_WIDTH  read burst length
- ch0_payload  input  PAYLOAD_WIDTH  read payload
- ch1_valid  input  1  write beat valid
- ch1_ready  output  1  write beat accepted when valid&&ready
- ch1_sop  input  1  first beat of a write burst
- ch1_burstcount  input  BURST_CNT_WIDTH  write burst length, sampled only on sop beat
- ch1_payload  input  PAYLOAD_WIDTH  write beat payload
- favor_ch0  input  1  from fairness tracker
- favor_ch1  input  1  from fairness tracker
- out_valid  output  1  merged request valid
- out_ready  input  1  downstream ready
- out_is_write  output  1  1 = beat from ch1
- out_sop  output  1  first beat of a burst (always 1 for reads)
- out_burstcount  output  BURST_CNT_WIDTH  burst length of the selected beat
- out_payload  output  PAYLOAD_WIDTH  selected payload
- fair_ch0_valid  output  1  read burst accepted this cycle
- fair_ch0_burstcount  output  BURST_CNT_WIDTH  its burstcount
- fair_ch1_valid  output  1  write burst sop accepted this cycle
- fair_ch1_burstcount  output  BURST_CNT_WIDTH  its burstcount

Behaviour:
- Reset (async, reset_n low): out_valid=0, beats_left=0, last_grant=ch1 (so ch0 wins the first tie). All out_* data outputs and fair_* outputs are 0. State is held until reset_n is released. Reset mid-burst abandons the burst; no partial-burst recovery.
- Stage enable: stage_en = !out_valid || out_ready. ch0_ready and ch1_ready are driven only from stage_en and the grant, never from the *_valid inputs of the same channel.
- Lock: while beats_left != 0, only ch1 is eligible. ch0_ready=0; ch1_ready=stage_en.
- Unlocked arbitration, decided in the same cycle:
  - Only one channel valid: grant it.
  - Both valid: favor_ch0 -> ch0; else favor_ch1 -> ch1; else grant the opposite of last_grant.
  - favor_ch0 and favor_ch1 both high (illegal): ch0 wins.
- Unlocked ch1 beat without ch1_sop: protocol error. The beat is accepted as a 1-beat burst and flagged by a simulation assertion.
- Accept: grant && valid && stage_en. On accept, the output register loads payload, is_write, sop and burstcount; out_valid <= 1; last_grant <= the accepted channel. If stage_en && no accept, out_valid <= 0. Latency is 1 cycle from accept to out_valid.
- Beat counter (BURST_CNT_WIDTH bits):
  - On an accepted ch1 sop beat with burstcount N: beats_left <= N-1.
  - On an accepted ch1 non-sop beat: beats_left <= beats_left-1.
  - burstcount 0 is illegal; it is treated as 1 and flagged by a simulation assertion.
  - N = 2^W-1 must not wrap.
- out_burstcount on non-sop write beats carries the burst's latched N.
- fair_ch0_*: combinational, fair_ch0_valid = ch0 accept.
- fair_ch1_*: combinational, fair_ch1_valid = ch1 sop accept. Non-sop beats do not pulse.
- out_ready low with out_valid high: the output register holds stable, both channel readies are 0, and beats_left is unchanged.

Test Plan:
- Reset release, ch0_valid=1, burstcount=1, out_ready=1 -> ch0_ready=1 in cycle 0; out_valid=1, out_is_write=0, out_sop=1 in cycle 1; fair_ch0_valid pulses in cycle 0 with burstcount 1.
- Write sop burstcount=4, ch0_valid held high throughout -> 4 consecutive write beats on out with out_sop=1,0,0,0; ch0_ready=0 until the 4th beat is accepted; read granted on the next cycle.
- Both channels valid, 1-beat writes, favor_* = 0 -> grants alternate ch0,ch1,ch0,ch1 starting with ch0 after reset.
- Both valid, favor_ch1=1 held -> ch1 granted on every unlocked cycle. Drop favor_ch1 and raise favor_ch0 -> ch0 granted on the next unlocked cycle.
- Output back-pressure: out_ready=0 for 3 cycles mid-burst (burstcount=8) -> out_payload stable, beats_left frozen; after release the remaining beats complete with a beat count of exactly 8.
- reset_n asserted asynchronously mid-burst (beats_left=5) -> out_valid=0 immediately, without a clock edge; after release, ch0 is grantable with no lock.
